// File: rtl/bus_timer_periph_if.sv
// CPU data-bus bundle between the core (master) and the timer responder (slave).
interface bus_timer_periph_if;
  logic        busWe;
  logic [31:0] busAddr;
  logic [31:0] busWData;
  logic [3:0]  Byte_Enable;
  logic [31:0] busRData;

  modport master (output busWe, busAddr, busWData, Byte_Enable, input busRData);
  modport slave  (input busWe, busAddr, busWData, Byte_Enable, output busRData);
endinterface

// File: rtl/bus_timer_periph.sv
// Memory-mapped prescaled timer: compare match, auto-reload, overflow, sticky W1C flags, level irq.
// Define TIMER_CAPTURE_EN to add the cap_in input capture (CAP register, STAT.CAPF, CTRL.CAP_IRQ_EN).
module bus_timer_periph #(
  parameter logic [31:0] BASE_ADDR = 32'h1000_1000,
  parameter int          CNT_W     = 32,
  parameter int          PSC_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
`ifdef TIMER_CAPTURE_EN
  input  logic              cap_in,
`endif
  bus_timer_periph_if.slave bus,
  output logic              irq
);

  localparam logic [2:0] IDX_CTRL = 3'd0;
  localparam logic [2:0] IDX_PSC  = 3'd1;
  localparam logic [2:0] IDX_CNT  = 3'd2;
  localparam logic [2:0] IDX_CMP  = 3'd3;
  localparam logic [2:0] IDX_STAT = 3'd4;
  localparam logic [2:0] IDX_CAP  = 3'd5;
  localparam logic [CNT_W-1:0] CNT_ONES = {CNT_W{1'b1}};

  function automatic logic [31:0] f_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    end
    return res;
  endfunction

  logic             r_en, r_auto, r_irq_en, r_match, r_ovf, r_irq;
  logic [PSC_W-1:0] r_psc, r_pcnt;
  logic [CNT_W-1:0] r_cnt, r_cmp;
  logic             w_en_n, w_auto_n, w_irq_en_n, w_match_n, w_ovf_n, w_irq_n;
  logic [PSC_W-1:0] w_psc_n, w_pcnt_n;
  logic [CNT_W-1:0] w_cnt_n, w_cmp_n;
  logic             w_sel, w_wr, w_wr_ctrl, w_tick, w_tick_eff, w_hit, w_clear, w_w1c;
  logic             w_match_set, w_ovf_set, w_cap_irq, w_ctrl_hi, w_stat_hi, w_unused;
  logic [2:0]       w_idx;
  logic [31:0]      w_wdata, w_rdata;
  logic [3:0]       w_be;

  assign w_sel     = (bus.busAddr[31:5] == BASE_ADDR[31:5]);
  assign w_idx     = bus.busAddr[4:2];
  assign w_wr      = w_sel & bus.busWe;
  assign w_wdata   = bus.busWData;
  assign w_be      = bus.Byte_Enable;
  assign w_unused  = ^bus.busAddr[1:0];
  assign w_wr_ctrl = w_wr & (w_idx == IDX_CTRL) & w_be[0];
  assign w_clear   = w_wr_ctrl & w_wdata[3];
  assign w_w1c     = w_wr & (w_idx == IDX_STAT) & w_be[0];
  assign w_tick    = r_en & (r_pcnt == r_psc);
  // CLEAR suppresses the whole tick, including the flag updates it would cause
  assign w_tick_eff  = w_tick & ~w_clear;
  assign w_hit       = (r_cnt == r_cmp);
  assign w_match_set = w_tick_eff & w_hit;
  assign w_ovf_set   = w_tick_eff & (r_cnt == CNT_ONES) & ~(w_hit & r_auto);

`ifdef TIMER_CAPTURE_EN
  logic             r_cap_irq_en, r_capf, r_cap_prev;
  logic [1:0]       r_sync;
  logic [CNT_W-1:0] r_cap;
  logic             w_cap_irq_en_n, w_capf_n, w_cap_evt;

  assign w_cap_evt = r_sync[1] & ~r_cap_prev;
  assign w_cap_irq = w_cap_irq_en_n & w_capf_n;
  assign w_ctrl_hi = r_cap_irq_en;
  assign w_stat_hi = r_capf;

  // Capture enable and sticky CAPF next state
  always_comb begin
    w_cap_irq_en_n = r_cap_irq_en;
    if (w_wr_ctrl) begin
      w_cap_irq_en_n = w_wdata[4];
    end else begin
      w_cap_irq_en_n = r_cap_irq_en;
    end
    w_capf_n = (r_capf & ~(w_w1c & w_wdata[2])) | w_cap_evt;
  end

  // Two-flop synchronizer, edge detect and capture registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync       <= 2'b00;
      r_cap_prev   <= 1'b0;
      r_cap_irq_en <= 1'b0;
      r_capf       <= 1'b0;
      r_cap        <= '0;
    end else begin
      r_sync       <= {r_sync[0], cap_in};
      r_cap_prev   <= r_sync[1];
      r_cap_irq_en <= w_cap_irq_en_n;
      r_capf       <= w_capf_n;
      if (w_cap_evt) begin
        r_cap <= r_cnt;
      end
    end
  end
`else
  assign w_cap_irq = 1'b0;
  assign w_ctrl_hi = 1'b0;
  assign w_stat_hi = 1'b0;
`endif

  // Next-state for control, prescaler, counter and status
  always_comb begin
    w_en_n     = r_en;
    w_auto_n   = r_auto;
    w_irq_en_n = r_irq_en;
    w_psc_n    = r_psc;
    w_pcnt_n   = r_pcnt;
    w_cnt_n    = r_cnt;
    w_cmp_n    = r_cmp;
    if (w_wr_ctrl) begin
      w_en_n     = w_wdata[0];
      w_auto_n   = w_wdata[1];
      w_irq_en_n = w_wdata[2];
    end else begin
      w_en_n     = r_en;
    end
    if (w_wr && (w_idx == IDX_PSC)) begin
      w_psc_n = PSC_W'(f_merge(32'(r_psc), w_wdata, w_be));
    end else begin
      w_psc_n = r_psc;
    end
    if (w_wr && (w_idx == IDX_CMP)) begin
      w_cmp_n = CNT_W'(f_merge(32'(r_cmp), w_wdata, w_be));
    end else begin
      w_cmp_n = r_cmp;
    end
    if (w_clear) begin
      w_pcnt_n = '0;
    end else if (w_tick) begin
      w_pcnt_n = '0;
    end else if (r_en) begin
      w_pcnt_n = r_pcnt + PSC_W'(1'b1);
    end else begin
      w_pcnt_n = r_pcnt;
    end
    // A bus write to CNT outranks the tick; CLEAR outranks both
    if (w_clear) begin
      w_cnt_n = '0;
    end else if (w_wr && (w_idx == IDX_CNT)) begin
      w_cnt_n = CNT_W'(f_merge(32'(r_cnt), w_wdata, w_be));
    end else if (w_tick_eff && w_hit && r_auto) begin
      w_cnt_n = '0;
    end else if (w_tick_eff) begin
      w_cnt_n = r_cnt + CNT_W'(1'b1);
    end else begin
      w_cnt_n = r_cnt;
    end
    w_match_n = (r_match & ~(w_w1c & w_wdata[0])) | w_match_set;
    w_ovf_n   = (r_ovf & ~(w_w1c & w_wdata[1])) | w_ovf_set;
    w_irq_n   = (w_irq_en_n & (w_match_n | w_ovf_n)) | w_cap_irq;
  end

  // Timer state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_en     <= 1'b0;
      r_auto   <= 1'b0;
      r_irq_en <= 1'b0;
      r_psc    <= '0;
      r_pcnt   <= '0;
      r_cnt    <= '0;
      r_cmp    <= '0;
      r_match  <= 1'b0;
      r_ovf    <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      r_en     <= w_en_n;
      r_auto   <= w_auto_n;
      r_irq_en <= w_irq_en_n;
      r_psc    <= w_psc_n;
      r_pcnt   <= w_pcnt_n;
      r_cnt    <= w_cnt_n;
      r_cmp    <= w_cmp_n;
      r_match  <= w_match_n;
      r_ovf    <= w_ovf_n;
      r_irq    <= w_irq_n;
    end
  end

  // Zero-wait read mux
  always_comb begin
    w_rdata = 32'h0;
    if (w_sel) begin
      case (w_idx)
        IDX_CTRL: w_rdata = {27'h0, w_ctrl_hi, 1'b0, r_irq_en, r_auto, r_en};
        IDX_PSC:  w_rdata = 32'(r_psc);
        IDX_CNT:  w_rdata = 32'(r_cnt);
        IDX_CMP:  w_rdata = 32'(r_cmp);
        IDX_STAT: w_rdata = {29'h0, w_stat_hi, r_ovf, r_match};
`ifdef TIMER_CAPTURE_EN
        IDX_CAP:  w_rdata = 32'(r_cap);
`endif
        default:  w_rdata = 32'h0;
      endcase
    end else begin
      w_rdata = 32'h0;
    end
  end

  assign bus.busRData = w_rdata;
  assign irq          = r_irq;

endmodule

// File: tb/tb_bus_timer_periph.sv
// Directed bench for bus_timer_periph with a behavioural register model checked every cycle.
module tb_bus_timer_periph;
  localparam logic [31:0] BASE = 32'h1000_1000;
  localparam logic [31:0] A_CTRL = BASE + 32'h00;
  localparam logic [31:0] A_PSC  = BASE + 32'h04;
  localparam logic [31:0] A_CNT  = BASE + 32'h08;
  localparam logic [31:0] A_CMP  = BASE + 32'h0C;
  localparam logic [31:0] A_STAT = BASE + 32'h10;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic irq;
  int   n_vec = 0;
  int   n_err = 0;

  bus_timer_periph_if bif ();

  bus_timer_periph #(.BASE_ADDR(BASE), .CNT_W(32), .PSC_W(16)) dut (
    .clk    (clk),
    .reset  (reset),
`ifdef TIMER_CAPTURE_EN
    .cap_in (1'b0),
`endif
    .bus    (bif),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  // Model state: register contents as software sees them
  bit        m_en, m_ar, m_ie, m_match, m_ovf, m_irq;
  bit [15:0] m_psc, m_pcnt;
  bit [31:0] m_cnt, m_cmp;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  function automatic bit in_window(input logic [31:0] a);
    return (a >> 5) == (BASE >> 5);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [2:0] idx;
    idx = a[4:2];
    if (!in_window(a)) return 32'h0;
    case (idx)
      3'd0:    return {29'h0, m_ie, m_ar, m_en};
      3'd1:    return {16'h0, m_psc};
      3'd2:    return m_cnt;
      3'd3:    return m_cmp;
      3'd4:    return {30'h0, m_ovf, m_match};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_en = 0; m_ar = 0; m_ie = 0; m_match = 0; m_ovf = 0; m_irq = 0;
    m_psc = 16'h0; m_pcnt = 16'h0; m_cnt = 32'h0; m_cmp = 32'h0;
  endtask

  task automatic model_step();
    bit          wr, clr, tk;
    logic [2:0]  idx;
    logic [31:0] wd, mask, a;
    logic [3:0]  be;
    logic [32:0] inc;
    a    = bif.busAddr;
    wd   = bif.busWData;
    be   = bif.Byte_Enable;
    idx  = a[4:2];
    wr   = in_window(a) && bif.busWe;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    clr  = wr && idx == 3'd0 && be[0] && wd[3];
    tk   = m_en && (m_pcnt == m_psc) && !clr;
    if (clr) m_pcnt = 16'h0;
    else if (m_en) m_pcnt = (m_pcnt == m_psc) ? 16'h0 : m_pcnt + 16'h1;
    // flags are cleared first so a same-edge event re-sets them
    if (wr && idx == 3'd4 && be[0]) begin
      if (wd[0]) m_match = 0;
      if (wd[1]) m_ovf = 0;
    end
    if (tk) begin
      if (m_cnt == m_cmp) m_match = 1;
      if (m_cnt == m_cmp && m_ar) m_cnt = 32'h0;
      else begin
        inc = {1'b0, m_cnt} + 33'd1;
        if (inc[32]) m_ovf = 1;
        m_cnt = inc[31:0];
      end
    end
    if (wr && idx == 3'd0 && be[0]) begin
      m_en = wd[0]; m_ar = wd[1]; m_ie = wd[2];
    end
    if (wr && idx == 3'd1) m_psc = 16'(({16'h0, m_psc} & ~mask) | (wd & mask));
    if (wr && idx == 3'd2) m_cnt = (m_cnt & ~mask) | (wd & mask);
    if (wr && idx == 3'd3) m_cmp = (m_cmp & ~mask) | (wd & mask);
    if (clr) m_cnt = 32'h0;
    m_irq = m_ie && (m_match || m_ovf);
  endtask

  always @(negedge reset) model_reset();

  always @(posedge clk) begin
    if (reset) model_step();
  end

  // Per-cycle compare of irq and read data against the model
  always @(negedge clk) begin
    if (reset) begin
      check("irq_cycle", {31'h0, irq}, {31'h0, m_irq});
      check("rdata_cycle", bif.busRData, model_read(bif.busAddr));
    end
  end

  task automatic step(input logic we, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be);
    bif.busWe = we; bif.busAddr = a; bif.busWData = d; bif.Byte_Enable = be;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, A_CNT, 32'h0, 4'h0);
  endtask

  task automatic peek(input logic [31:0] a, input logic [31:0] exp, input string nm);
    bif.busWe = 1'b0; bif.busAddr = a;
    #1;
    check(nm, bif.busRData, exp);
  endtask

  initial begin
    model_reset();
    bif.busWe = 1'b0; bif.busAddr = 32'h0; bif.busWData = 32'h0; bif.Byte_Enable = 4'h0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    for (int i = 0; i < 6; i++) peek(BASE + 32'(4 * i), 32'h0, "reset_readback");

    step(1'b1, A_CMP, 32'h1234_5678, 4'hF);
    peek(A_CMP, 32'h1234_5678, "cmp_full_write");
    step(1'b1, A_CMP, 32'h0000_AB00, 4'b0010);
    peek(A_CMP, 32'h1234_AB78, "cmp_byte_lane");

    step(1'b1, A_PSC, 32'd3, 4'hF);
    step(1'b1, A_CTRL, 32'h1, 4'h1);
    idle(40);
    peek(A_CNT, 32'd10, "prescale_cnt");
    step(1'b1, A_CTRL, 32'h8, 4'h1);
    peek(A_CNT, 32'h0, "clear_cnt");
    peek(A_CTRL, 32'h0, "clear_reads_zero");

    step(1'b1, A_PSC, 32'h0, 4'hF);
    step(1'b1, A_CMP, 32'd5, 4'hF);
    step(1'b1, A_CTRL, 32'h7, 4'h1);
    idle(5);
    peek(A_CNT, 32'd5, "reload_cnt5");
    check("irq_before_match", {31'h0, irq}, 32'h0);
    idle(1);
    peek(A_CNT, 32'h0, "reload_wrap");
    peek(A_STAT, 32'h1, "reload_match");
    check("irq_after_match", {31'h0, irq}, 32'h1);
    step(1'b1, A_STAT, 32'h1, 4'h1);
    check("irq_after_w1c", {31'h0, irq}, 32'h0);
    peek(A_STAT, 32'h0, "stat_w1c");
    idle(4);
    peek(A_CNT, 32'd5, "collide_pre");
    step(1'b1, A_STAT, 32'h1, 4'h1);
    peek(A_STAT, 32'h1, "w1c_vs_set");
    step(1'b1, A_CNT, 32'h100, 4'hF);
    peek(A_CNT, 32'h100, "cnt_write_on_tick");
    step(1'b1, A_CTRL, 32'h0, 4'h1);
    step(1'b1, A_STAT, 32'h3, 4'h1);

    step(1'b1, A_CNT, 32'hFFFF_FFFE, 4'hF);
    step(1'b1, A_CMP, 32'h10, 4'hF);
    step(1'b1, A_CTRL, 32'h1, 4'h1);
    idle(2);
    peek(A_CNT, 32'h0, "ovf_cnt");
    peek(A_STAT, 32'h2, "ovf_stat");

    step(1'b1, A_CTRL, 32'h0, 4'h1);
    step(1'b1, A_STAT, 32'h3, 4'h1);
    step(1'b1, A_CMP, 32'hFFFF_FFFF, 4'hF);
    step(1'b1, A_CNT, 32'hFFFF_FFFF, 4'hF);
    step(1'b1, A_CTRL, 32'h5, 4'h1);
    idle(1);
    peek(A_STAT, 32'h3, "match_and_ovf");
    check("irq_match_ovf", {31'h0, irq}, 32'h1);

    step(1'b1, BASE + 32'h20, 32'hFFFF_FFFF, 4'hF);
    peek(BASE + 32'h20, 32'h0, "unselected_read");
    peek(A_CTRL, 32'h5, "unselected_no_write");
    step(1'b1, BASE + 32'h18, 32'hFFFF_FFFF, 4'hF);
    peek(BASE + 32'h18, 32'h0, "unmapped_read");
    step(1'b1, A_CMP + 32'h2, 32'h77, 4'hF);
    peek(A_CMP, 32'h77, "addr_low_ignored");

    idle(3);
    #1 reset = 1'b0;
    #1 check("rst_async_cnt", bif.busRData, 32'h0);
    check("rst_async_irq", {31'h0, irq}, 32'h0);
    bif.busAddr = A_STAT;
    #1 check("rst_async_stat", bif.busRData, 32'h0);
    @(posedge clk);
    #2 reset = 1'b1;
    idle(3);
    peek(A_CNT, 32'h0, "post_reset_idle");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
